// File: rtl/ex_seq_pkg.sv
// Shared EX-stage encodings: ALU op codes, result classes and FSM states.
// EX_ITER_SHIFT_EN selects the iterative (1 bit/cycle) shifter over the barrel shifter.
package ex_seq_pkg;

    localparam logic [7:0] EXE_AND_OP = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP  = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP = 8'b0010_0111;
    localparam logic [7:0] EXE_SLL_OP = 8'b0111_1100;
    localparam logic [7:0] EXE_SRL_OP = 8'b0000_0010;
    localparam logic [7:0] EXE_SRA_OP = 8'b0000_0011;

    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;

    typedef enum logic [0:0] {
        EX_ST_IDLE  = 1'b0,
        EX_ST_SHIFT = 1'b1
    } ex_state_t;

    function automatic logic is_shift_aluop(input logic [7:0] op);
        return (op == EXE_SLL_OP) || (op == EXE_SRL_OP) || (op == EXE_SRA_OP);
    endfunction

endpackage

// File: rtl/ex_seq_shift_unit.sv
// Shifter for the EX stage: barrel (one cycle) or iterative (1 bit per cycle)
// when EX_ITER_SHIFT_EN is defined. done marks the cycle the result is valid.
module ex_shift_unit
    import ex_seq_pkg::*;
#(
    parameter int DW  = 32,
    parameter int SHW = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           stall,
    input  logic           flush,
    input  logic           start,
    input  logic [SHW-1:0] amt,
    input  logic [DW-1:0]  src,
    input  logic [7:0]     op,
    output logic           done,
    output logic [DW-1:0]  result
);

`ifdef EX_ITER_SHIFT_EN
    logic [DW-1:0]  acc;
    logic [SHW-1:0] cnt;
    logic [7:0]     op_q;
    logic           sign;
    logic [DW-1:0]  acc_step;

    // sign is captured from the original operand so SRA fill never depends on acc
    always_comb begin
        acc_step = '0;
        case (op_q)
            EXE_SLL_OP: acc_step = {acc[DW-2:0], 1'b0};
            EXE_SRL_OP: acc_step = {1'b0, acc[DW-1:1]};
            EXE_SRA_OP: acc_step = {sign, acc[DW-1:1]};
            default:    acc_step = '0;
        endcase
    end

    assign done   = (start && amt == '0) || (cnt == SHW'(1) && !stall && !flush);
    assign result = start ? src : acc_step;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            cnt  <= '0;
            op_q <= '0;
            sign <= 1'b0;
        end else if (flush) begin
            cnt <= '0;
        end else if (!stall) begin
            if (start && amt != '0) begin
                acc  <= src;
                cnt  <= amt;
                op_q <= op;
                sign <= src[DW-1];
            end else if (cnt != '0) begin
                acc <= acc_step;
                cnt <= cnt - SHW'(1);
            end
        end
    end
`else
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst, stall, flush};

    always_comb begin
        result = '0;
        case (op)
            EXE_SLL_OP: result = src << amt;
            EXE_SRL_OP: result = src >> amt;
            EXE_SRA_OP: result = DW'($signed(src) >>> amt);
            default:    result = '0;
        endcase
    end

    assign done = start;
`endif

endmodule

// File: rtl/ex_seq.sv
// EX stage with integrated EX/MEM register: logic ops and shifts, forwarding to ID.
// With EX_ITER_SHIFT_EN defined, shifts run 1 bit/cycle and stall upstream while busy.
module ex_seq
    import ex_seq_pkg::*;
#(
    parameter int DW  = 32,
    parameter int AW  = 5,
    parameter int SHW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [7:0]    aluop_i,
    input  logic [2:0]    alusel_i,
    input  logic [DW-1:0] reg1_i,
    input  logic [DW-1:0] reg2_i,
    input  logic [AW-1:0] wd_i,
    input  logic          wreg_i,
    input  logic          stall_i,
    input  logic          flush_i,
    output logic          stallreq_o,
    output logic          fwd_wreg_o,
    output logic [AW-1:0] fwd_wd_o,
    output logic [DW-1:0] fwd_wdata_o,
    output logic          mem_wreg_o,
    output logic [AW-1:0] mem_wd_o,
    output logic [DW-1:0] mem_wdata_o
);

    ex_state_t     state;
    logic [AW-1:0] wd_q;
    logic          wreg_q;
    logic          accept, is_shift_op, sh_start, sh_done;
    logic [DW-1:0] sh_result, logic_res, res_data;
    logic [AW-1:0] res_wd;
    logic          res_wreg, complete;

    // flush also blocks acceptance: anything taken this cycle would be discarded
    assign in_ready_o  = !rst && !flush_i && !stall_i && state == EX_ST_IDLE;
    assign accept      = in_valid_i && in_ready_o;
    assign is_shift_op = alusel_i == EXE_RES_SHIFT && is_shift_aluop(aluop_i);
    assign sh_start    = accept && is_shift_op;
    assign stallreq_o  = !rst && state == EX_ST_SHIFT;

    ex_shift_unit #(.DW(DW), .SHW(SHW)) u_shift (
        .clk    (clk),
        .rst    (rst),
        .stall  (stall_i),
        .flush  (flush_i),
        .start  (sh_start),
        .amt    (reg1_i[SHW-1:0]),
        .src    (reg2_i),
        .op     (aluop_i),
        .done   (sh_done),
        .result (sh_result)
    );

    always_comb begin
        logic_res = '0;
        case (aluop_i)
            EXE_OR_OP:  logic_res = reg1_i | reg2_i;
            EXE_AND_OP: logic_res = reg1_i & reg2_i;
            EXE_XOR_OP: logic_res = reg1_i ^ reg2_i;
            EXE_NOR_OP: logic_res = ~(reg1_i | reg2_i);
            default:    logic_res = '0;
        endcase
    end

    always_comb begin
        complete = 1'b0;
        res_wd   = wd_i;
        res_wreg = wreg_i;
        res_data = '0;
        if (state == EX_ST_SHIFT) begin
            complete = sh_done && !rst;
            res_wd   = wd_q;
            res_wreg = wreg_q;
            res_data = sh_result;
        end else if (accept) begin
            complete = is_shift_op ? sh_done : 1'b1;
            res_data = is_shift_op ? sh_result :
                       (alusel_i == EXE_RES_LOGIC) ? logic_res : '0;
        end
        fwd_wreg_o  = complete && res_wreg;
        fwd_wd_o    = complete ? res_wd : '0;
        fwd_wdata_o = complete ? res_data : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= EX_ST_IDLE;
            wd_q        <= '0;
            wreg_q      <= 1'b0;
            mem_wreg_o  <= 1'b0;
            mem_wd_o    <= '0;
            mem_wdata_o <= '0;
        end else if (flush_i) begin
            state       <= EX_ST_IDLE;
            mem_wreg_o  <= 1'b0;
            mem_wd_o    <= '0;
            mem_wdata_o <= '0;
        end else if (!stall_i) begin
            // fwd_* is already zero when nothing completes, so this also loads bubbles
            mem_wreg_o  <= fwd_wreg_o;
            mem_wd_o    <= fwd_wd_o;
            mem_wdata_o <= fwd_wdata_o;
            case (state)
                EX_ST_IDLE: if (sh_start && !sh_done) begin
                    state  <= EX_ST_SHIFT;
                    wd_q   <= wd_i;
                    wreg_q <= wreg_i;
                end
                EX_ST_SHIFT: if (sh_done) state <= EX_ST_IDLE;
                default: state <= EX_ST_IDLE;
            endcase
        end
    end

endmodule
